button_panel_ctl: RTL and testbench
===================================

Name: button_panel_ctl

Overview:
Parametrised successor to the fixed three-button click logic (deal/hit/stand). It decodes mouse position and left-button state against N_BTN equal rectangular buttons laid out in one row. It emits a one-cycle click pulse only on a clean press-and-release inside the same enabled button. It also provides hover and pressed vectors for the button-drawing stage, and sits between hold_mouse and the game FSM / draw_buttons.

Parameters:
N_BTN, 3, number of buttons (1..8)
BTN_X0, 100, left x of button 0 (pixels)
BTN_Y0, 500, top y of all buttons
BTN_W, 120, button width (pixels)
BTN_H, 40, button height (pixels)
BTN_GAP, 20, horizontal gap between adjacent buttons
DEBOUNCE_CYCLES, 0, stable cycles required before left-button change is accepted; 0 = bypass

Ports:
clk  input  1  system clock (pixel clock domain)
rst  input  1  asynchronous active-high reset
mouse_x  input  12  cursor x (already in clk domain)
mouse_y  input  12  cursor y
left_mouse  input  1  left button level, 1 = pressed
btn_en  input  N_BTN  per-button enable (driven from FSM state)
hover  output  N_BTN  one-hot or zero: enabled button under cursor
pressed  output  N_BTN  one-hot or zero: button currently held
click  output  N_BTN  one-cycle one-hot click pulse
click_idx  output  3  index of last click, held until the next click

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0; the FSM resets to IDLE; the debounce counter resets to 0; the debounced level resets to 0.
- Geometry: button i covers x in [BTN_X0+i*(BTN_W+BTN_GAP), BTN_X0+i*(BTN_W+BTN_GAP)+BTN_W-1] and y in [BTN_Y0, BTN_Y0+BTN_H-1], inclusive.
  - Compares are unsigned at 12 bits; parameter sums are computed at 13 bits to avoid wrap.
- Stage 1 (registered): capture mouse_x, mouse_y and left_mouse.
  - Compute hit[i] = inside(i) & btn_en[i] combinationally from the registered values.
  - Buttons do not overlap, so hit is at most one-hot.
- Debounce: a counter restarts whenever the registered raw level differs from the debounced level.
  - The debounced level flips after DEBOUNCE_CYCLES consecutive differing samples.
  - With DEBOUNCE_CYCLES=0 the debounced level equals the stage-1 level.
- FSM states and transitions (registered):
  - IDLE: debounced press rising edge with hit!=0 -> PRESSED, latching idx = encode(hit). Rising edge with hit==0 -> WAIT_REL.
  - PRESSED: release while hit[idx]=1 -> IDLE, click[idx] pulses next cycle, click_idx <= idx. Release while hit[idx]=0 -> IDLE, no click. Still held and btn_en[idx] drops -> WAIT_REL.
  - WAIT_REL: release -> IDLE, no click. Dragging into a button never arms it.
- Outputs:
  - hover = hit, registered: 2 cycles from the input change.
  - pressed = onehot(idx) while in PRESSED and hit[idx]=1, else 0; registered.
  - click is registered and high exactly one cycle.
- Latency: with DEBOUNCE_CYCLES=0, a left_mouse 1->0 sampled at edge k gives click high in the cycle after edge k+2. Each debounce cycle adds 1.
- Simultaneous press and move is evaluated on the same registered sample, with no ordering race.
- Press and release both occurring between samples is not detected and is acceptable, since mouse level is held by hold_mouse.
- Reset mid-press forces IDLE with no click, including when rst is released while the button is still held.
  - After such a reset the FSM waits in IDLE. It enters WAIT_REL only on a new rising edge, so a press held through reset is ignored until released and pressed again.
- Enable mask changes take effect on hover within 2 cycles.

Decomposition:
- Package btn_pkg: typedef enum logic [1:0] {IDLE, PRESSED, WAIT_REL} btn_state_t; default geometry constants; localparam for max N_BTN=8.
- Sub-module btn_debounce (parametrised DEBOUNCE_CYCLES, 1-bit level in/out) is natural and is reused for the right button later.
- Hit test is a generate loop inside the top; no separate module.

Test Plan:
- N_BTN=3, defaults, btn_en=3'b111: cursor (150,520), press then release -> click=3'b001 for exactly 1 cycle, click_idx=0, pressed=001 while held.
- Press at (300,510) on button 1, move to (420,510) on button 2, release -> no click; pressed goes 010 then 000; hover follows to 100.
- Press at (230,520) in the gap, drag to (260,520), release -> no click; FSM passes through WAIT_REL.
- Hold button 2 at (499,539) (corner inclusive), deassert btn_en[2], release -> no click; hover drops to 000 within 2 cycles. Also check (500,539) and (499,540) give hover=000.
- DEBOUNCE_CYCLES=4: 3-cycle glitch low during a hold on button 0 -> no click; a clean release gives click 4 cycles later than the bypass case.
- Assert rst for 1 cycle while PRESSED on button 1 -> all outputs 0 immediately (async); subsequent release gives no click; next full press/release clicks normally.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the button panel click logic.
//   btn_state_t : click FSM states
//   MAX_BTN     : widest panel supported (sets click_idx width)
//   DEF_*       : default panel geometry in pixels
//   enc_idx     : index of the highest set bit of a one-hot vector
package btn_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        WAIT_REL = 2'd2
    } btn_state_t;

    localparam int MAX_BTN     = 8;
    localparam int DEF_BTN_X0  = 100;
    localparam int DEF_BTN_Y0  = 500;
    localparam int DEF_BTN_W   = 120;
    localparam int DEF_BTN_H   = 40;
    localparam int DEF_BTN_GAP = 20;

    function automatic logic [2:0] enc_idx(input logic [MAX_BTN-1:0] v);
        enc_idx = '0;
        for (int i = 0; i < MAX_BTN; i++)
            if (v[i]) enc_idx = 3'(i);
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Level debouncer for a mouse button.
//   clk, rst  : clock, async active-high reset
//   level_in  : raw (already synchronised) level
//   level_out : debounced level, flips after DEBOUNCE_CYCLES consecutive
//               samples that differ from it; 0 = pass-through
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic level_out
);
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign level_out      = level_in;
        end else begin : g_filt
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] cnt;
            logic          lvl;

            // Any sample agreeing with the current level restarts the run.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                end else if (level_in == lvl) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt <= '0;
                    lvl <= level_in;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign level_out = lvl;
        end
    endgenerate
endmodule

// File: rtl/button_panel_ctl.sv
// Click logic for a row of N_BTN equal rectangular buttons.
//   clk, rst         : pixel clock, async active-high reset
//   mouse_x, mouse_y : cursor position
//   left_mouse       : left button level (1 = pressed)
//   btn_en           : per-button enable
//   hover            : enabled button under the cursor (registered)
//   pressed          : button currently held with cursor still on it
//   click            : one-cycle pulse on a clean press/release in one button
//   click_idx        : index of the last click, held
module button_panel_ctl
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int BTN_X0          = DEF_BTN_X0,
    parameter int BTN_Y0          = DEF_BTN_Y0,
    parameter int BTN_W           = DEF_BTN_W,
    parameter int BTN_H           = DEF_BTN_H,
    parameter int BTN_GAP         = DEF_BTN_GAP,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      mouse_x,
    input  logic [11:0]      mouse_y,
    input  logic             left_mouse,
    input  logic [N_BTN-1:0] btn_en,
    output logic [N_BTN-1:0] hover,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] click,
    output logic [2:0]       click_idx
);
    // Stage 1: input capture
    logic [11:0] mx_r, my_r;
    logic        lm_r;
    logic        smp_vld;   // stage-1 registers hold a real sample

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mx_r    <= '0;
            my_r    <= '0;
            lm_r    <= 1'b0;
            smp_vld <= 1'b0;
        end else begin
            mx_r    <= mouse_x;
            my_r    <= mouse_y;
            lm_r    <= left_mouse;
            smp_vld <= 1'b1;
        end
    end

    // Hit test, 13-bit bounds so parameter sums cannot wrap.
    logic [N_BTN-1:0] hit;
    localparam logic [12:0] YL = 13'(BTN_Y0);
    localparam logic [12:0] YH = 13'(BTN_Y0 + BTN_H - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_hit
        localparam logic [12:0] XL = 13'(BTN_X0 + i * (BTN_W + BTN_GAP));
        localparam logic [12:0] XH = 13'(BTN_X0 + i * (BTN_W + BTN_GAP) + BTN_W - 1);
        assign hit[i] = btn_en[i]
                      && ({1'b0, mx_r} >= XL) && ({1'b0, mx_r} <= XH)
                      && ({1'b0, my_r} >= YL) && ({1'b0, my_r} <= YH);
    end

    logic deb;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk      (clk),
        .rst      (rst),
        .level_in (lm_r),
        .level_out(deb)
    );

    // Stage 2: level history for edge detection, hover register.
    // armed stays low until a released sample is seen after reset, so a
    // press held through reset cannot masquerade as a fresh rising edge.
    logic deb_q, deb_q2, armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q  <= 1'b0;
            deb_q2 <= 1'b0;
            armed  <= 1'b0;
            hover  <= '0;
        end else begin
            deb_q  <= deb;
            deb_q2 <= deb_q;
            armed  <= armed | (smp_vld & ~lm_r);
            hover  <= hit;
        end
    end

    // Click FSM
    btn_state_t       state;
    logic [2:0]       idx;
    logic [N_BTN-1:0] idx_oh;
    logic             rise, hov_idx, en_idx;

    assign idx_oh  = N_BTN'(1) << idx;
    assign rise    = deb_q & ~deb_q2 & armed;
    assign hov_idx = |(hover & idx_oh);
    assign en_idx  = |(btn_en & idx_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pressed   <= '0;
            click     <= '0;
            click_idx <= '0;
        end else begin
            click   <= '0;
            pressed <= '0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        if (|hover) begin
                            state   <= PRESSED;
                            idx     <= enc_idx(MAX_BTN'(hover));
                            pressed <= hover;
                        end else begin
                            state <= WAIT_REL;
                        end
                    end
                end
                PRESSED: begin
                    if (!deb_q) begin
                        state <= IDLE;
                        if (hov_idx) begin
                            click     <= idx_oh;
                            click_idx <= idx;
                        end
                    end else if (!en_idx) begin
                        state <= WAIT_REL;
                    end else begin
                        pressed <= hover & idx_oh;
                    end
                end
                WAIT_REL: begin
                    if (!deb_q) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_button_panel_ctl.sv
// Scoreboard bench: two instances (debounce bypass and 4-cycle debounce).
// Stimulus pushes expected clicks (vector, index, cycle) into per-DUT
// queues; negedge monitors pop and compare on every nonzero click.
module tb_button_panel_ctl;
    import btn_pkg::*;

    typedef struct {
        logic [2:0] vec;
        logic [2:0] idx;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mx, my;
    logic        lm, lm4;
    logic [2:0]  en;
    logic [2:0]  hover, pressed, click, click_idx;
    logic [2:0]  hover4, pressed4, click4, click_idx4;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_panel_ctl #(.N_BTN(3), .DEBOUNCE_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .mouse_x(mx), .mouse_y(my), .left_mouse(lm),
        .btn_en(en), .hover(hover), .pressed(pressed), .click(click),
        .click_idx(click_idx)
    );

    button_panel_ctl #(.N_BTN(3), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .mouse_x(mx), .mouse_y(my), .left_mouse(lm4),
        .btn_en(en), .hover(hover4), .pressed(pressed4), .click(click4),
        .click_idx(click_idx4)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move(input int x, input int y);
        mx = 12'(x);
        my = 12'(y);
    endtask

    // Monitors
    always @(negedge clk) begin
        if (!rst && click != 3'b000) begin
            if (q0.size() == 0) begin
                check("click0_unexpected", 32'(click), 32'(0));
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("click0_vec", 32'(click), 32'(e.vec));
                check("click0_idx", 32'(click_idx), 32'(e.idx));
                check("click0_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && click4 != 3'b000) begin
            if (q4.size() == 0) begin
                check("click4_unexpected", 32'(click4), 32'(0));
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("click4_vec", 32'(click4), 32'(e.vec));
                check("click4_idx", 32'(click_idx4), 32'(e.idx));
                check("click4_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; lm = 1'b0; lm4 = 1'b0; en = 3'b111;
        move(0, 0);
        tick(2);
        check("rst_hover",     32'(hover),     32'(0));
        check("rst_pressed",   32'(pressed),   32'(0));
        check("rst_click",     32'(click),     32'(0));
        check("rst_click_idx", 32'(click_idx), 32'(0));
        check("rst_state",     32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick(3);

        // 1: clean click on button 0
        move(150, 520); tick(3);
        check("t1_hover", 32'(hover), 32'(3'b001));
        lm = 1'b1; tick(4);
        check("t1_pressed", 32'(pressed), 32'(3'b001));
        q0.push_back('{vec: 3'b001, idx: 3'd0, cyc: cyc + 3});
        lm = 1'b0; tick(6);
        check("t1_pressed_rel", 32'(pressed), 32'(0));
        check("t1_click_idx",   32'(click_idx), 32'(0));
        check("t1_q_empty",     32'(q0.size()), 32'(0));

        // 2: press button 1, move to button 2, release -> no click
        move(300, 510); tick(3);
        lm = 1'b1; tick(4);
        check("t2_pressed_b1", 32'(pressed), 32'(3'b010));
        move(420, 510); tick(4);
        check("t2_pressed_off", 32'(pressed), 32'(0));
        check("t2_hover_b2",    32'(hover),   32'(3'b100));
        lm = 1'b0; tick(6);
        check("t2_state", 32'(dut.state), 32'(IDLE));

        // 3: press in the gap, drag onto button 1 -> no click
        move(230, 520); tick(3);
        check("t3_hover_gap", 32'(hover), 32'(0));
        lm = 1'b1; tick(4);
        check("t3_wait_rel", 32'(dut.state), 32'(WAIT_REL));
        move(260, 520); tick(4);
        check("t3_hover_b1",  32'(hover),     32'(3'b010));
        check("t3_pressed",   32'(pressed),   32'(0));
        check("t3_still_wr",  32'(dut.state), 32'(WAIT_REL));
        lm = 1'b0; tick(4);
        check("t3_idle", 32'(dut.state), 32'(IDLE));

        // 4: hold button 2 at its corner, disable it, release -> no click
        move(499, 539); tick(3);
        check("t4_hover_corner", 32'(hover), 32'(3'b100));
        lm = 1'b1; tick(4);
        check("t4_pressed", 32'(pressed), 32'(3'b100));
        en = 3'b011; tick(2);
        check("t4_hover_dis", 32'(hover),     32'(0));
        check("t4_wait_rel",  32'(dut.state), 32'(WAIT_REL));
        lm = 1'b0; tick(5);
        en = 3'b111;
        move(500, 539); tick(3);
        check("t4_hover_x_out", 32'(hover), 32'(0));
        move(499, 540); tick(3);
        check("t4_hover_y_out", 32'(hover), 32'(0));
        move(380, 500); tick(3);
        check("t4_hover_tl", 32'(hover), 32'(3'b100));

        // 5: 4-cycle debounce instance on button 0
        move(150, 520); tick(3);
        lm4 = 1'b1; tick(10);
        check("t5_pressed", 32'(pressed4), 32'(3'b001));
        lm4 = 1'b0; tick(3);
        lm4 = 1'b1; tick(10);
        check("t5_glitch_held", 32'(pressed4),   32'(3'b001));
        check("t5_glitch_st",   32'(dut4.state), 32'(PRESSED));
        q4.push_back('{vec: 3'b001, idx: 3'd0, cyc: cyc + 7});
        lm4 = 1'b0; tick(12);
        check("t5_q_empty", 32'(q4.size()), 32'(0));

        // 6: async reset while pressed on button 1
        move(300, 510); tick(3);
        lm = 1'b1; tick(4);
        check("t6_pressed", 32'(pressed), 32'(3'b010));
        #2 rst = 1'b1;
        #1;
        check("t6_async_hover",   32'(hover),     32'(0));
        check("t6_async_pressed", 32'(pressed),   32'(0));
        check("t6_async_idx",     32'(click_idx), 32'(0));
        check("t6_async_state",   32'(dut.state), 32'(IDLE));
        tick(1);
        rst = 1'b0;
        tick(4);
        check("t6_held_idle", 32'(dut.state), 32'(IDLE));
        check("t6_held_prs",  32'(pressed),   32'(0));
        lm = 1'b0; tick(5);
        check("t6_rel_idle", 32'(dut.state), 32'(IDLE));
        lm = 1'b1; tick(4);
        check("t6_re_pressed", 32'(pressed), 32'(3'b010));
        q0.push_back('{vec: 3'b010, idx: 3'd1, cyc: cyc + 3});
        lm = 1'b0; tick(6);
        check("t6_click_idx", 32'(click_idx), 32'(1));
        check("t6_q_empty",   32'(q0.size()), 32'(0));

        tick(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
